// File: rtl/matrix_scanner_pkg.sv
// matrix_scanner shared types.
// FSM states, key event bundle and counter width.
package matrix_scanner_pkg;

  localparam int CNT_W = 4;
  localparam int EVT_KEY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_EMIT,
    ST_NEXT
  } state_t;

  typedef struct packed {
    logic [EVT_KEY_W-1:0] key;
    logic                 pressed;
  } evt_t;

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: per-key stable state.
// Flips after DEBOUNCE_SCANS disagreeing scans.
module debounce_cell
  import matrix_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_upd,
  input  logic i_sample,
  output logic o_stable,
  output logic o_flip
);

  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_diff    = i_sample ^ r_stable;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign o_flip    = i_upd & w_diff &
                     (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS));
  assign o_stable  = r_stable;

  // count disagreeing scans, adopt the sample once enough accrue
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (i_upd) begin
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (o_flip) begin
        r_stable <= i_sample;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/matrix_scanner.sv
// matrix_scanner: column strobe, row sample, debounce,
// and press/release events over valid/ready.
module matrix_scanner
  import matrix_scanner_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 12,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int KEY_W          = $clog2(ROWS*COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_tick,
  input  logic [ROWS-1:0]  row_sense,
  output logic [COLS-1:0]  col_drive,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KEY_W-1:0] evt_key,
  output logic             evt_pressed,
  output logic             busy,
  output logic             overrun
);

  localparam int NK = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
    $error("DEBOUNCE_SCANS must be in 1..15");
  end

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_col, w_col_nx;
  logic [SW-1:0]   r_cnt, w_cnt_nx;
  logic [ROWS-1:0] r_pend, w_pend_nx;
  logic [ROWS-1:0] r_sync1, r_sync2;
  logic            r_overrun;
  logic [NK-1:0]   w_stable, w_flip;
  logic [COLS-1:0] w_upd;
  logic [ROWS-1:0] w_col_flip, w_col_stable, w_sel;
  logic [RW-1:0]   w_row;
  evt_t            w_evt;
  logic            w_unused_key;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign w_upd[c] = (r_state == ST_SAMPLE) &&
                      (r_col == CW'(c));
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      debounce_cell #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_cell (
        .clk     (clk),
        .rst     (rst),
        .i_upd   (w_upd[c]),
        .i_sample(r_sync2[r]),
        .o_stable(w_stable[c*ROWS+r]),
        .o_flip  (w_flip[c*ROWS+r])
      );
    end
  end

  // fold the strobed column's cells down to per-row views
  always_comb begin
    w_col_flip   = '0;
    w_col_stable = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        w_col_flip[r] = w_col_flip[r] | w_flip[c*ROWS+r];
        w_col_stable[r] = w_col_stable[r] |
          ((r_col == CW'(c)) & w_stable[c*ROWS+r]);
      end
    end
  end

  // lowest pending row is presented first
  always_comb begin
    w_row = '0;
    w_sel = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (r_pend[r]) begin
        w_row = RW'(r);
        w_sel = ROWS'(1) << r;
      end
    end
  end

  assign w_evt.key     = EVT_KEY_W'(int'(r_col) * ROWS + int'(w_row));
  assign w_evt.pressed = w_col_stable[w_row];
  assign w_unused_key  = ^w_evt.key;
  assign busy          = (r_state != ST_IDLE);
  assign overrun       = r_overrun;

  // next-state and outputs
  always_comb begin
    w_state_nx  = r_state;
    w_col_nx    = r_col;
    w_cnt_nx    = r_cnt;
    w_pend_nx   = r_pend;
    col_drive   = '0;
    evt_valid   = 1'b0;
    evt_key     = '0;
    evt_pressed = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (scan_tick) begin
          w_state_nx = ST_DRIVE;
          w_col_nx   = '0;
          w_cnt_nx   = '0;
        end
      end
      ST_DRIVE: begin
        col_drive = COLS'(1) << r_col;
        if (r_cnt == SW'(SETTLE_CYCLES - 1)) begin
          w_state_nx = ST_SAMPLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_SAMPLE: begin
        col_drive  = COLS'(1) << r_col;
        w_pend_nx  = w_col_flip;
        w_state_nx = (|w_col_flip) ? ST_EMIT : ST_NEXT;
      end
      ST_EMIT: begin
        evt_valid   = 1'b1;
        evt_key     = w_evt.key[KEY_W-1:0];
        evt_pressed = w_evt.pressed;
        if (evt_ready) begin
          w_pend_nx = r_pend & ~w_sel;
          if ((r_pend & ~w_sel) == '0) begin
            w_state_nx = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (r_col == CW'(COLS - 1)) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_DRIVE;
          w_col_nx   = r_col + 1'b1;
          w_cnt_nx   = '0;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
    end
  end

  // two-flop synchronizer for the raw row lines
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= row_sense;
      r_sync2 <= r_sync1;
    end
  end

  // sticky flag for ticks that land during a scan
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (scan_tick && busy) begin
      r_overrun <= 1'b1;
    end
  end

endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Key-matrix scanning front end for the keyboard FPGA. It strobes one column at a time and samples the row lines after a settle interval. Each key is debounced across successive full scans, and stable press/release changes are emitted as key events over a valid/ready handshake. It sits between the physical matrix pins and the report/encoder logic. Scans are started by an external periodic pulse from a tick counter.

## Interface
- `ROWS`, 4, number of row sense lines.
- `COLS`, 12, number of column drive lines.
- `SETTLE_CYCLES`, 8, cycles each column is driven before sampling. Minimum 3; elaboration error if smaller.
- `DEBOUNCE_SCANS`, 4, consecutive disagreeing scans needed to flip a key's stable state. Range 1..15.
- `KEY_W`, `$clog2(ROWS*COLS)`, width of the key index.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `scan_tick` in 1: one-cycle pulse requesting a full matrix scan.
- `row_sense` in ROWS: raw row inputs, asynchronous, 1 = key closed. Synchronized internally.
- `col_drive` out COLS: one-hot column strobe, all-zero when not driving.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event.
- `evt_key` out KEY_W: key index = col*ROWS + row.
- `evt_pressed` out 1: 1 = press, 0 = release.
- `busy` out 1: scan in progress (state != IDLE).
- `overrun` out 1: sticky; set when `scan_tick` arrives while busy.

## Operation
- Reset (rst=0 at a clock edge):
  - State IDLE.
  - `col_drive`, `evt_valid`, `evt_key`, `evt_pressed`, `busy`, `overrun` all 0.
  - All stable key states 0 (released), all debounce counters 0, sync flops 0.
  - Reset asserted mid-scan or mid-handshake aborts immediately; the pending event is discarded.
- Input path: `row_sense` passes through a 2-flop synchronizer, giving `row_sync` with 2 cycles latency.
- FSM states:
  - IDLE: `scan_tick`=1 → DRIVE, col=0, settle counter cleared.
  - DRIVE: `col_drive`=1<<col. After SETTLE_CYCLES cycles → SAMPLE.
  - SAMPLE: `col_drive` still asserted. Debounce cells for column col are updated from `row_sync`, and the pending mask is latched: one bit per row whose stable state flipped. Nonzero mask → EMIT; otherwise → NEXT.
  - EMIT: `col_drive`=0.
    - Presents the lowest set pending row: `evt_key`=col*ROWS+row, `evt_pressed`=new stable state.
    - On `evt_valid && evt_ready`, that bit is cleared. The next set bit is presented the following cycle; if none remain → NEXT.
    - The FSM stalls indefinitely while `evt_ready`=0. `evt_valid`, `evt_key` and `evt_pressed` hold stable.
  - NEXT: `col_drive`=0. If col==COLS-1 → IDLE; otherwise col+1 → DRIVE.
- Debounce cell, one per key, updated only in SAMPLE of its column:
  - sample == stable: counter ← 0.
  - Otherwise counter+1. When it reaches DEBOUNCE_SCANS, stable ← sample, counter ← 0, and the key's pending bit is set.
  - The counter never exceeds DEBOUNCE_SCANS.
- `scan_tick` while busy=1, including the NEXT cycle of the last column: ignored, `overrun` ← 1. `overrun` is cleared only by reset.

## Timing
- `scan_tick` at cycle t (IDLE) → `col_drive`=1<<0 from t+1.
- Each column drives for SETTLE_CYCLES+1 cycles (DRIVE+SAMPLE).
- An event-free column occupies SETTLE_CYCLES+2 cycles; each accepted event adds 1 cycle.
- An event-free full scan keeps busy high for COLS*(SETTLE_CYCLES+2) cycles.
- With `evt_ready` held high, events from one column appear on consecutive cycles, one per cycle, ascending row order.
- The sampled value reflects `row_sense` at least SETTLE_CYCLES-2 cycles after the strobe rises.
- Minimum press-to-event latency: DEBOUNCE_SCANS scans.

## Structure
- Shared package `matrix_scanner_pkg`:
  - state enum (IDLE, DRIVE, SAMPLE, EMIT, NEXT);
  - event struct {key, pressed};
  - localparam for the counter width (4 bits).
- Sub-module `debounce_cell`: stable bit, 4-bit counter, update strobe, flip pulse. Instantiated ROWS*COLS times via generate.

## Test plan
Parameters for all scenarios: ROWS=2, COLS=3, SETTLE_CYCLES=3, DEBOUNCE_SCANS=2.
- Reset: rst=0 for 3 cycles with scan_tick=1 → all outputs 0, no column driven after release until a new tick.
- Empty scan:
  - Stimulus: tick at t.
  - Response: `col_drive`=001 for t+1..t+4, 010 for t+6..t+9, 100 for t+11..t+14; busy low at t+16; no evt_valid.
- Press row1 col2, held:
  - Scan 1: no event.
  - Scan 2: evt_key=5, evt_pressed=1 in the col2 EMIT.
  - Releasing the key for 2 scans → evt_key=5, evt_pressed=0.
- Bounce: row0 col0 closed in scan 1 only, open in scan 2 → no event; counter back to 0.
- Two keys plus backpressure:
  - Stimulus: rows 0 and 1 of col1 debounced in the same scan; evt_ready=0 for 10 cycles.
  - Response: evt_key=2 held stable for 10 cycles, col_drive=0.
  - After ready rises: key 3 on the next cycle, then NEXT.
- Overrun: tick while busy → overrun=1, scan not restarted, busy timing unchanged; stays 1 until reset.
